// File: rtl/muldiv_pkg.sv
// Shared types for the exe_muldiv multiply/divide unit: op encoding, FSM states, default width.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/exe_muldiv_if.sv
// Issue/writeback handshake bundle between the execute stage and exe_muldiv.
interface exe_muldiv_if
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [4:0]      rd_in;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [4:0]      out_rd;
   logic            busy;

   modport master (
      output in_valid, op, rs1_fwd, rs2_fwd, rd_in, out_ready,
      input  in_ready, out_valid, out_result, out_rd, busy
   );

   modport slave (
      input  in_valid, op, rs1_fwd, rs2_fwd, rd_in, out_ready,
      output in_ready, out_valid, out_result, out_rd, busy
   );
endinterface

// File: rtl/muldiv_mul_pipe.sv
// Free-running MUL_LAT-stage multiplier; operand signedness chosen per op, 2*XLEN-bit product.
module muldiv_mul_pipe #(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic              a_signed,
   input  logic              b_signed,
   output logic [2*XLEN-1:0] product
);
   logic [2*XLEN-1:0] a_ext_s;
   logic [2*XLEN-1:0] b_ext_s;
   logic [2*XLEN-1:0] stage_d [MUL_LAT];
   logic [2*XLEN-1:0] stage_q [MUL_LAT];

   // Extending both operands to 2*XLEN makes the low 2*XLEN product bits exact for any sign mix.
   always_comb begin
      a_ext_s    = {{XLEN{a_signed & a[XLEN-1]}}, a};
      b_ext_s    = {{XLEN{b_signed & b[XLEN-1]}}, b};
      stage_d[0] = a_ext_s * b_ext_s;
      for (int i = 1; i < MUL_LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign product = stage_q[MUL_LAT-1];

endmodule

// File: rtl/exe_muldiv.sv
// Single-op RV32M/RV64M multiply/divide unit (IDLE/MUL/DIV/DONE) with a restoring radix-2 divider.
// Build option MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish 2 cycles after accept.
module exe_muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   exe_muldiv_if.slave bus
);
   localparam int              CW       = 7;
   localparam logic [CW-1:0]   DIV_ITER = CW'(XLEN);
   localparam logic [CW-1:0]   MUL_LOAD = CW'(MUL_LAT - 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   op_e             op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] rs1_q, rs1_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic            dz_q, dz_d, ovf_q, ovf_d;

   op_e               op_in_s;
   logic              sgn_in_s, a_neg_s, b_neg_s, dz_in_s, ovf_in_s;
   logic              mul_a_signed_s, mul_b_signed_s, ge_s, is_rem_s;
   logic [XLEN-1:0]   a_mag_s, b_mag_s;
   logic [XLEN:0]     rem_sh_s;
   logic [CW-1:0]     div_load_s;
   logic [2*XLEN-1:0] prod_s;

   function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

   muldiv_mul_pipe #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_mul (
      .clk      (clk),
      .reset    (reset),
      .a        (bus.rs1_fwd),
      .b        (bus.rs2_fwd),
      .a_signed (mul_a_signed_s),
      .b_signed (mul_b_signed_s),
      .product  (prod_s)
   );

   always_comb begin
      op_in_s        = op_e'(bus.op);
      sgn_in_s       = (op_in_s == OP_DIV) || (op_in_s == OP_REM);
      a_neg_s        = sgn_in_s & bus.rs1_fwd[XLEN-1];
      b_neg_s        = sgn_in_s & bus.rs2_fwd[XLEN-1];
      a_mag_s        = a_neg_s ? neg(bus.rs1_fwd) : bus.rs1_fwd;
      b_mag_s        = b_neg_s ? neg(bus.rs2_fwd) : bus.rs2_fwd;
      dz_in_s        = (bus.rs2_fwd == '0);
      ovf_in_s       = sgn_in_s && (bus.rs1_fwd == MOST_NEG) && (bus.rs2_fwd == '1);
      mul_a_signed_s = (op_in_s != OP_MULHU);
      mul_b_signed_s = (op_in_s == OP_MUL) || (op_in_s == OP_MULH);
      rem_sh_s       = {rem_q, quo_q[XLEN-1]};
      ge_s           = (rem_sh_s >= {1'b0, dvs_q});
      is_rem_s       = (op_q == OP_REM) || (op_q == OP_REMU);
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign div_load_s = (dz_in_s || ovf_in_s) ? CW'(1) : DIV_ITER;
`else
   assign div_load_s = DIV_ITER;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      res_d   = res_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               op_d    = op_in_s;
               rd_d    = bus.rd_in;
               rs1_d   = bus.rs1_fwd;
               dvs_d   = b_mag_s;
               quo_d   = a_mag_s;
               rem_d   = '0;
               q_neg_d = a_neg_s ^ b_neg_s;
               r_neg_d = a_neg_s;
               dz_d    = dz_in_s;
               ovf_d   = ovf_in_s;
               state_d = bus.op[2] ? S_DIV : S_MUL;
               cnt_d   = bus.op[2] ? div_load_s : MUL_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               res_d   = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            if (cnt_q != '0) begin
               rem_d = ge_s ? (rem_sh_s[XLEN-1:0] - dvs_q) : rem_sh_s[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], ge_s};
               cnt_d = cnt_q - CW'(1);
            end else begin
               // Corner cases override whatever the iterations left behind.
               if (dz_q) begin
                  res_d = is_rem_s ? rs1_q : '1;
               end else if (ovf_q) begin
                  res_d = is_rem_s ? '0 : rs1_q;
               end else if (is_rem_s) begin
                  res_d = r_neg_q ? neg(rem_q) : rem_q;
               end else begin
                  res_d = q_neg_q ? neg(quo_q) : quo_q;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MUL;
         rd_q    <= '0;
         rs1_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         res_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = (state_q == S_DONE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.out_result = res_q;
   assign bus.out_rd     = rd_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed self-checking bench for exe_muldiv (XLEN=32, MUL_LAT=2); honours MULDIV_EARLY_OUT_EN.
module tb_exe_muldiv;
   localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 2;
`else
   localparam int SPECIAL_LAT = 33;
`endif

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   lat;
   int   seen;

   exe_muldiv_if #(.XLEN(XLEN)) bus ();

   exe_muldiv #(.XLEN(XLEN), .MUL_LAT(2)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.rs1_fwd  = a;
      bus.rs2_fwd  = b;
      bus.rd_in    = rd;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.rs1_fwd  = 32'hDEAD_BEEF;
      bus.rs2_fwd  = 32'h0BAD_F00D;
   endtask

   // Counts edges after the accept edge until out_valid shows, bounded at 200.
   task automatic wait_valid(output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
      int n;
      drive(op, a, b, rd);
      check($sformatf("%s.busy", tag), 32'(bus.busy), 32'd1);
      wait_valid(n);
      check($sformatf("%s.latency", tag), 32'(n), 32'(exp_lat));
      check($sformatf("%s.result", tag), bus.out_result, exp_res);
      check($sformatf("%s.rd", tag), 32'(bus.out_rd), 32'(rd));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check($sformatf("%s.valid_drop", tag), 32'(bus.out_valid), 32'd0);
      check($sformatf("%s.ready_back", tag), 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      reset         = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 3'b000;
      bus.rs1_fwd   = 32'h0;
      bus.rs2_fwd   = 32'h0;
      bus.rd_in     = 5'd0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst.in_ready",   32'(bus.in_ready),  32'd1);
      check("rst.out_valid",  32'(bus.out_valid), 32'd0);
      check("rst.busy",       32'(bus.busy),      32'd0);
      check("rst.out_result", bus.out_result,     32'h0);
      check("rst.out_rd",     32'(bus.out_rd),    32'd0);

      do_op("mul_7x-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2);
      do_op("mulhu_ff",       3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 2);
      do_op("mulh_ff",        3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 2);
      do_op("mulhsu_ff",      3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 2);
      do_op("mulh_2x8000",    3'b001, 32'd2,          32'h8000_0000, 5'd5,  32'hFFFF_FFFF, 2);
      do_op("mulhsu_2x8000",  3'b010, 32'd2,          32'h8000_0000, 5'd6,  32'h0000_0001, 2);
      do_op("div_-7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,          5'd7,  32'hFFFF_FFFD, 33);
      do_op("rem_-7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,          5'd8,  32'hFFFF_FFFF, 33);
      do_op("div_7/-2",       3'b100, 32'd7,          32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, 33);
      do_op("rem_7/-2",       3'b110, 32'd7,          32'hFFFF_FFFE, 5'd10, 32'h0000_0001, 33);
      do_op("divu_100/7",     3'b101, 32'd100,        32'd7,          5'd11, 32'h0000_000E, 33);
      do_op("remu_100/7",     3'b111, 32'd100,        32'd7,          5'd12, 32'h0000_0002, 33);
      do_op("divu_big/2",     3'b101, 32'hFFFF_FFF9, 32'd2,          5'd13, 32'h7FFF_FFFC, 33);
      do_op("divu_8000/ff",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 33);
      do_op("remu_8000/ff",   3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 33);
      do_op("divu_5/0",       3'b101, 32'd5,          32'd0, 5'd16, 32'hFFFF_FFFF, SPECIAL_LAT);
      do_op("rem_5/0",        3'b110, 32'd5,          32'd0, 5'd17, 32'h0000_0005, SPECIAL_LAT);
      do_op("div_-7/0",       3'b100, 32'hFFFF_FFF9, 32'd0, 5'd18, 32'hFFFF_FFFF, SPECIAL_LAT);
      do_op("remu_-7/0",      3'b111, 32'hFFFF_FFF9, 32'd0, 5'd19, 32'hFFFF_FFF9, SPECIAL_LAT);
      do_op("rem_ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, SPECIAL_LAT);
      do_op("div_ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, SPECIAL_LAT);

      // Result must hold while writeback stalls.
      drive(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd9);
      wait_valid(lat);
      check("hold.latency", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold%0d.valid", i),  32'(bus.out_valid), 32'd1);
         check($sformatf("hold%0d.result", i), bus.out_result,     32'h2345_6780);
         check($sformatf("hold%0d.rd", i),     32'(bus.out_rd),    32'd9);
         check($sformatf("hold%0d.in_rdy", i), 32'(bus.in_ready),  32'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("hold.released", 32'(bus.out_valid), 32'd0);

      // Flush ten cycles into a divide while a new op is offered.
      drive(3'b101, 32'd100, 32'd7, 5'd3);
      repeat (10) @(negedge clk);
      check("flush.busy_before", 32'(bus.busy), 32'd1);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.op       = 3'b000;
      bus.rs1_fwd  = 32'd3;
      bus.rs2_fwd  = 32'd4;
      bus.rd_in    = 5'd4;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush.busy",      32'(bus.busy),      32'd0);
      check("flush.in_ready",  32'(bus.in_ready),  32'd1);
      check("flush.out_valid", 32'(bus.out_valid), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      check("flush.no_result", 32'(seen), 32'd0);
      check("flush.idle_after", 32'(bus.busy), 32'd0);

      // Reset mid-multiply discards the op and clears the outputs.
      drive(3'b000, 32'd7, 32'd3, 5'd5);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstmid.busy",      32'(bus.busy),      32'd0);
      check("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
      check("rstmid.out_result", bus.out_result,    32'h0);
      check("rstmid.out_rd",    32'(bus.out_rd),    32'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen++;
      end
      check("rstmid.no_result", 32'(seen), 32'd0);

      // Flush beats a same-cycle writeback handshake.
      drive(3'b101, 32'd100, 32'd7, 5'd6);
      wait_valid(lat);
      check("flushdone.latency", 32'(lat), 32'd33);
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      flush         = 1'b0;
      bus.out_ready = 1'b0;
      check("flushdone.out_valid", 32'(bus.out_valid), 32'd0);
      check("flushdone.busy",      32'(bus.busy),      32'd0);

      do_op("mul_recover", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd31, 32'hFFFF_FFEB, 2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
